// File: rtl/rr_mux_4to1.sv
// rtl/rr_mux_4to1.sv - four-stream round-robin collector with registered output stage
module rr_mux_4to1 #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready
);

  logic [1:0] last_grant;
  logic [1:0] grant;
  logic [1:0] scan_idx;
  logic       grant_valid;
  logic       load_en;
  logic       take;

  assign load_en = !out_valid || out_ready;
  assign take    = load_en && grant_valid && !rst;

  // Scan starts one past the last winner so every requester waits at most three grants.
  always_comb begin
    grant_valid = 1'b0;
    grant       = last_grant;
    scan_idx    = last_grant;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_grant + 2'(k);
      if (!grant_valid && in_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant       = scan_idx;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (take) begin
      in_ready = 4'b0001 << grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'b00;
      last_grant <= 2'd3;
    end else if (take) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[grant*DATA_W +: DATA_W];
      out_sel    <= grant;
      last_grant <= grant;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
